pattern_serial_tx: RTL and testbench
====================================

Name: pattern_serial_tx

Overview:
- Serial pattern transmitter: accepts a WIDTH-bit parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single-bit line.
- Supplies framed bit streams to the serial pattern/sequence detectors, on-chip or in benches, in place of hand-written bit-by-bit stimulus.
- Inserts a configurable idle gap between frames.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- GAP, 2, idle cycles after each frame before a new load is accepted; 0 is legal.
- IDLE_LEVEL, 1'b0, level driven on out when no frame bit is being sent.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- load_data  input  WIDTH  word to transmit; sampled only on the handshake edge.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  block can accept a word; combinational from state (high only in IDLE).
- out  output  WIDTH-independent 1  serial data, registered.
- out_valid  output  1  high while out carries a frame bit, registered.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse, registered, aligned with the final bit of the frame on out.

Behaviour:
- Reset values (reset==0, asynchronous): state=IDLE, shift register=0, bit counter=0, gap counter=0, out=IDLE_LEVEL, out_valid=0, done=0, busy=0, load_ready=1.
- FSM states:
  - IDLE -> SHIFT on load_valid&&load_ready.
  - SHIFT -> GAP after last bit if GAP>0, else -> IDLE.
  - GAP -> IDLE after GAP cycles.
- Handshake edge E0:
  - Captures load_data into the shift register.
  - out<=load_data[WIDTH-1], out_valid<=1.
  - First bit is visible in the cycle immediately after E0 (1-cycle latency).
- Edges E1..E(WIDTH-1): out<=next lower bit; out_valid stays 1.
- At edge E(WIDTH-1): out<=load_data[0] and done<=1 (done high for exactly that cycle).
- Edge E(WIDTH):
  - out<=IDLE_LEVEL, out_valid<=0, done<=0.
  - Enter GAP, or IDLE if GAP==0.
- GAP: out=IDLE_LEVEL, out_valid=0, busy=1, load_ready=0 for exactly GAP cycles; then IDLE.
- load_ready therefore returns high at edge E(WIDTH+GAP).
- Minimum frame period: WIDTH+GAP cycles of busy, plus the IDLE cycle in which the handshake occurs.
- load_valid while not in IDLE is ignored; no word is queued or lost from internal state.
- load_data changes after E0 do not affect the frame in flight.
- Bit counter width is $clog2(WIDTH+1); gap counter width is $clog2(GAP+1), minimum 1. No wrap-around is observable.
- Reset asserted mid-frame or mid-gap:
  - Frame aborts immediately; all outputs return to reset values.
  - done is not pulsed for the aborted frame.
- Reset release: first handshake is possible at the first rising edge with reset==1.
- load_valid held high continuously gives back-to-back frames separated by exactly GAP idle cycles plus one IDLE cycle.

Optional Feature:
- Macro: PATTERN_SERIAL_TX_PARITY_EN.
- Defined:
  - One extra bit is sent after data bit 0: even parity = XOR of all WIDTH data bits, with out_valid=1.
  - done moves to the parity-bit cycle.
  - GAP/IDLE timing shifts by one cycle, so load_ready returns at E(WIDTH+1+GAP).
- Undefined: frame is exactly WIDTH bits; no parity logic is synthesised.

Decomposition:
- Shared package pattern_tx_pkg:
  - state enum (IDLE, SHIFT, PARITY, GAP); PARITY exists only under the macro.
  - helper function for counter width.
- No sub-module: single FSM plus shift/count datapath in one module.

Test Plan:
- WIDTH=8, GAP=2, handshake with load_data=8'b1000_1011 -> out=1,0,0,0,1,0,1,1 over 8 cycles after E0; out_valid high for those 8; done only on the 8th; load_ready low until E10.
- load_valid held high with words 8'hA5 then 8'h3C -> two frames: 10100101, then 2 gap cycles at IDLE_LEVEL, 1 IDLE cycle, then 00111100; no word dropped or duplicated.
- load_valid pulsed at bit 3 of a frame, with load_data=8'hFF -> ignored; the current frame completes unchanged; load_ready stays 0.
- reset driven 0 at bit 5 of a frame -> out=IDLE_LEVEL, out_valid=0, busy=0, load_ready=1 without waiting for a clock edge; no done pulse.
- GAP=0, back-to-back 8'h01 and 8'h80 -> 00000001, one IDLE cycle, 10000000; done pulses twice.
- PATTERN_SERIAL_TX_PARITY_EN defined, load 8'b1011_0000 -> 9 valid bits ending with parity 1; done on the 9th bit; load_ready returns at E11.

Source files
------------

// File: rtl/pattern_serial_tx_pkg.sv
// Shared types for the serial pattern transmitter.
// The PARITY state exists only when PATTERN_SERIAL_TX_PARITY_EN is defined.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef PATTERN_SERIAL_TX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_GAP    = 2'd3
  } tx_state_t;

  // Width of a counter that must hold values 0..n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pattern_serial_tx_if.sv
// Load-side valid/ready handshake of the serial pattern transmitter.
interface pattern_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit word out MSB-first, then idles GAP cycles.
// Define PATTERN_SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module pattern_serial_tx
  import pattern_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  pattern_serial_tx_if.slave  load,
  output logic                out,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);
  localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
`ifdef PATTERN_SERIAL_TX_PARITY_EN
  logic             par_bit;
`endif

  assign load.load_ready = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);

  // shreg is pre-shifted at capture so its MSB is always the next bit to send
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      out       <= IDLE_LEVEL;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef PATTERN_SERIAL_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (load.load_valid) begin
            state     <= ST_SHIFT;
            shreg     <= load.load_data << 1;
            out       <= load.load_data[WIDTH-1];
            out_valid <= 1'b1;
            done      <= 1'b0;
            bit_cnt   <= BW'(1);
`ifdef PATTERN_SERIAL_TX_PARITY_EN
            par_bit   <= ^load.load_data;
`endif
          end
        end

        ST_SHIFT: begin
          if (bit_cnt != BIT_LAST) begin
            out     <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BW'(1);
`ifdef PATTERN_SERIAL_TX_PARITY_EN
            done    <= 1'b0;
`else
            done    <= (bit_cnt == BIT_PEN);
`endif
          end else begin
            bit_cnt <= '0;
`ifdef PATTERN_SERIAL_TX_PARITY_EN
            state     <= ST_PARITY;
            out       <= par_bit;
            out_valid <= 1'b1;
            done      <= 1'b1;
`else
            state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
            gap_cnt   <= '0;
            out       <= IDLE_LEVEL;
            out_valid <= 1'b0;
            done      <= 1'b0;
`endif
          end
        end

`ifdef PATTERN_SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
          gap_cnt   <= '0;
          out       <= IDLE_LEVEL;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
`endif

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          out       <= IDLE_LEVEL;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Directed bench for pattern_serial_tx: one instance with GAP=2/IDLE_LEVEL=0, one with GAP=0/IDLE_LEVEL=1.
// Expected frame length follows PATTERN_SERIAL_TX_PARITY_EN when the bench is built with it.
module tb_pattern_serial_tx;

`ifdef PATTERN_SERIAL_TX_PARITY_EN
  localparam logic PB = 1'b1;
`else
  localparam logic PB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  pattern_serial_tx_if #(.WIDTH(8)) if2 ();
  pattern_serial_tx_if #(.WIDTH(8)) if0 ();

  logic out2, ov2, busy2, done2;
  logic out0, ov0, busy0, done0;

  pattern_serial_tx #(.WIDTH(8), .GAP(2), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .load(if2),
    .out(out2), .out_valid(ov2), .busy(busy2), .done(done2)
  );

  pattern_serial_tx #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b1)) dut0 (
    .clk(clk), .reset(reset), .load(if0),
    .out(out0), .out_valid(ov0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic idle_lvl(input int d);
    return (d == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] data);
    if (d == 0) begin
      if0.load_valid = v;
      if0.load_data  = data;
    end else begin
      if2.load_valid = v;
      if2.load_data  = data;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input int d, input logic e_out,
                              input logic e_ov, input logic e_busy, input logic e_done,
                              input logic e_ready);
    if (d == 0) begin
      check({tag, " out"},   out0,           e_out);
      check({tag, " valid"}, ov0,            e_ov);
      check({tag, " busy"},  busy0,          e_busy);
      check({tag, " done"},  done0,          e_done);
      check({tag, " ready"}, if0.load_ready, e_ready);
    end else begin
      check({tag, " out"},   out2,           e_out);
      check({tag, " valid"}, ov2,            e_ov);
      check({tag, " busy"},  busy2,          e_busy);
      check({tag, " done"},  done2,          e_done);
      check({tag, " ready"}, if2.load_ready, e_ready);
    end
  endtask

  // Called #1 after the handshake edge; walks every data bit (and parity) of the frame
  task automatic expect_frame(input string tag, input int d, input logic [7:0] data,
                              input bit inject);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick();
      if (inject && j == 3) drive(d, 1'b1, 8'hFF);
      if (inject && j == 4) drive(d, 1'b0, 8'hFF);
      check_output($sformatf("%s bit%0d", tag, j), d, data[7-j], 1'b1, 1'b1,
                   (j == 7) && !PB, 1'b0);
    end
    if (PB) begin
      tick();
      check_output({tag, " parity"}, d, ^data, 1'b1, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic drain(input string tag, input int d, input int gap);
    for (int k = 0; k < gap; k++) begin
      tick();
      check_output($sformatf("%s gap%0d", tag, k), d, idle_lvl(d), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_output({tag, " idle"}, d, idle_lvl(d), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    tick();
    check_output("reset g2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("reset g0", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    check_output("post-reset g2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] single frame 8'h8B");
    drive(2, 1'b1, 8'h8B);
    tick();
    drive(2, 1'b0, 8'h00);
    expect_frame("f8B", 2, 8'h8B, 1'b0);
    drain("f8B", 2, 2);

    // Valid held high: second word loads right after the gap plus one IDLE cycle
    $display("[TB] back-to-back A5 then 3C");
    drive(2, 1'b1, 8'hA5);
    tick();
    drive(2, 1'b1, 8'h3C);
    expect_frame("fA5", 2, 8'hA5, 1'b0);
    drain("fA5", 2, 2);
    tick();
    drive(2, 1'b0, 8'h3C);
    expect_frame("f3C", 2, 8'h3C, 1'b0);
    drain("f3C", 2, 2);

    $display("[TB] ignored load mid-frame");
    drive(2, 1'b1, 8'h96);
    tick();
    drive(2, 1'b0, 8'h11);
    expect_frame("f96", 2, 8'h96, 1'b1);
    drain("f96", 2, 2);

    // Asynchronous reset at bit 5, checked between clock edges
    $display("[TB] reset mid-frame");
    drive(2, 1'b1, 8'hC3);
    tick();
    drive(2, 1'b0, 8'h00);
    for (int j = 1; j <= 5; j++) tick();
    check_output("rst bit5", 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_output("rst async", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output($sformatf("rst hold%0d", k), 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive(2, 1'b1, 8'h6D);
    reset = 1'b1;
    tick();
    drive(2, 1'b0, 8'h00);
    expect_frame("f6D", 2, 8'h6D, 1'b0);
    drain("f6D", 2, 2);

    $display("[TB] GAP=0 back-to-back 01 then 80");
    drive(0, 1'b1, 8'h01);
    tick();
    drive(0, 1'b1, 8'h80);
    expect_frame("g0 f01", 0, 8'h01, 1'b0);
    drain("g0 f01", 0, 0);
    tick();
    drive(0, 1'b0, 8'h00);
    expect_frame("g0 f80", 0, 8'h80, 1'b0);
    drain("g0 f80", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
